// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS constants, pipeline stage record and control-token lookup
package tmds_pkg;
  localparam int POP_W = 4;
  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;
  localparam logic [9:0] GUARD_02 = 10'h2CC;
  localparam logic [9:0] GUARD_1 = 10'h133;
  typedef struct packed {
    logic de;
    logic [1:0] c;
    logic [8:0] qm;
    logic [POP_W-1:0] n1;
  } stage_t;
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    return c == 2'b00 ? CTRL_00 : c == 2'b01 ? CTRL_01 : c == 2'b10 ? CTRL_10 : CTRL_11;
  endfunction
endpackage

// File: rtl/tmds_encoder_if.sv
// tmds_encoder_if: pixel-side inputs and the encoded 10-bit character
interface tmds_encoder_if;
  logic [7:0] in_data;
  logic in_de;
  logic [1:0] in_c;
  logic [9:0] out_tmds;
  modport master (output in_data, in_de, in_c, input out_tmds);
  modport slave (input in_data, in_de, in_c, output out_tmds);
endinterface

// File: rtl/tmds_qm.sv
// tmds_qm: stage-1 transition minimisation (XOR/XNOR chain) and popcount of q_m[7:0]
module tmds_qm
  import tmds_pkg::*;
(
  input  logic [7:0]       data,
  output logic [8:0]       qm,
  output logic [POP_W-1:0] n1
);
  logic [POP_W-1:0] nd;
  logic use_xnor;
  logic [7:0] chain;
  always_comb begin
    nd = POP_W'($countones(data));
    use_xnor = nd > 4 || (nd == 4 && !data[0]);
    chain = data;
    for (int i = 1; i < 8; i++) chain[i] = use_xnor ? ~(chain[i-1] ^ data[i]) : chain[i-1] ^ data[i];
    qm = {~use_xnor, chain};
    n1 = POP_W'($countones(chain));
  end
endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI TMDS lane encoder, latency 2; define TMDS_GUARD_BAND_EN for
// video guard-band insertion (two extra stages of lookahead, latency 4).
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input logic clk,
  input logic rst,
  tmds_encoder_if.slave io
);
`ifdef TMDS_GUARD_BAND_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 1;
`endif
  stage_t pipe [DEPTH];
  stage_t head;
  logic [8:0] qm;
  logic [POP_W-1:0] n1;
  logic signed [4:0] cnt, cnt_nx, diff;
  logic bal, flip;
  logic [9:0] tok;
  if (CHANNEL < 0 || CHANNEL > 2) begin : g_bad_channel
    $error("tmds_encoder: CHANNEL must be 0..2");
  end
  tmds_qm u_qm (.data(io.in_data), .qm(qm), .n1(n1));
  assign head = pipe[DEPTH-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      cnt <= '0;
      io.out_tmds <= CTRL_00;
    end else begin
      pipe[0] <= '{de: io.in_de, c: io.in_c, qm: qm, n1: n1};
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      cnt <= cnt_nx;
      io.out_tmds <= tok;
    end
  end
  // diff = N1 - N0 of q_m[7:0]; 5-bit wraparound keeps n1=8 correct at +8
  always_comb begin
    diff = signed'({head.n1, 1'b0}) - 5'sd8;
    bal = cnt == 0 || diff == 0;
    flip = (cnt > 0 && diff > 0) || (cnt < 0 && diff < 0);
    tok = bal ? {~head.qm[8], head.qm[8], head.qm[8] ? head.qm[7:0] : ~head.qm[7:0]}
              : {flip, head.qm[8], flip ? ~head.qm[7:0] : head.qm[7:0]};
    cnt_nx = bal ? (head.qm[8] ? cnt + diff : cnt - diff)
           : flip ? cnt - diff + (head.qm[8] ? 5'sd2 : 5'sd0)
           : cnt + diff - (head.qm[8] ? 5'sd0 : 5'sd2);
    if (!head.de) begin
      tok = ctrl_token(head.c);
      cnt_nx = '0;
`ifdef TMDS_GUARD_BAND_EN
      if (pipe[1].de || pipe[0].de) tok = CHANNEL == 1 ? GUARD_1 : GUARD_02;
`endif
    end
  end
endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: directed and random checks of the TMDS encoder against a cycle-history model
module tb_tmds_encoder;
`ifdef TMDS_GUARD_BAND_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int CH = 1;
  localparam int MAXC = 16384;
  logic clk = 1'b0;
  logic rst;
  tmds_encoder_if io ();
  tmds_encoder #(.CHANNEL(CH)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc_n = 0, run = 0;
  logic h_rst [MAXC];
  logic h_de [MAXC];
  logic [1:0] h_c [MAXC];
  logic [7:0] h_data [MAXC];
  logic h_vchk [MAXC];
  logic [9:0] h_exp [MAXC];
  string h_tag [MAXC];
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, cyc_n, got, got, exp, exp);
    end
  endtask
  function automatic logic [9:0] ctrl_ref(input logic [1:0] c);
    case (c)
      2'b00: return 10'h354;
      2'b01: return 10'h0AB;
      2'b10: return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction
  function automatic logic [7:0] decode(input logic [9:0] t);
    logic [7:0] q, d;
    q = t[9] ? ~t[7:0] : t[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = t[8] ? q[i] ^ q[i-1] : ~(q[i] ^ q[i-1]);
    return d;
  endfunction
  // input j is wiped if any reset was applied from its capture up to the edge producing output m
  function automatic logic cleared(input int j, input int m);
    if (j < 0) return 1'b1;
    for (int k = j; k <= m - 2; k++) if (h_rst[k]) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic eff(input int j, input int m);
    return !cleared(j, m) && h_de[j];
  endfunction
  task automatic evaluate(input int m);
    int n;
    logic [9:0] o, e;
    string tg;
    n = m - LAT;
    o = io.out_tmds;
    if (h_rst[m-1]) begin
      check("reset", int'(o), 10'h354);
      run = 0;
    end else if (eff(n, m)) begin
      if (h_vchk[n]) check(h_tag[n], int'(o), int'(h_exp[n]));
      else check("decode", int'(decode(o)), int'(h_data[n]));
      run += 2 * $countones(o) - 10;
      check("disparity", int'(run > 10 || run < -10), 0);
    end else begin
      e = ctrl_ref(cleared(n, m) ? 2'b00 : h_c[n]);
      tg = "ctrl";
`ifdef TMDS_GUARD_BAND_EN
      if (eff(n + 1, m) || eff(n + 2, m)) begin
        e = CH == 1 ? 10'h133 : 10'h2CC;
        tg = "guard";
      end
`endif
      check(tg, int'(o), int'(e));
      run = 0;
    end
  endtask
  task automatic drive(input logic r, input logic de_i, input logic [1:0] c, input logic [7:0] d,
                       input logic vchk, input logic [9:0] e, input string tag);
    @(negedge clk);
    cyc_n++;
    if (cyc_n >= MAXC) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc_n, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    evaluate(cyc_n);
    h_rst[cyc_n] = r; h_de[cyc_n] = de_i; h_c[cyc_n] = c; h_data[cyc_n] = d;
    h_vchk[cyc_n] = vchk; h_exp[cyc_n] = e; h_tag[cyc_n] = tag;
    rst = r; io.in_de = de_i; io.in_c = c; io.in_data = d;
  endtask
  task automatic idle(input logic [1:0] c);
    drive(1'b0, 1'b0, c, 8'h00, 1'b0, 10'h000, "ctrl");
  endtask
  task automatic vid(input logic [7:0] d, input logic [9:0] e);
    drive(1'b0, 1'b1, 2'b00, d, 1'b1, e, "video");
  endtask
  task automatic rvid(input logic [7:0] d);
    drive(1'b0, 1'b1, 2'b00, d, 1'b0, 10'h000, "decode");
  endtask
  initial begin
    rst = 1'b1; io.in_de = 1'b0; io.in_c = 2'b00; io.in_data = 8'h00;
    h_rst[0] = 1'b1; h_de[0] = 1'b0; h_c[0] = 2'b00; h_data[0] = 8'h00;
    h_vchk[0] = 1'b0; h_exp[0] = 10'h000; h_tag[0] = "reset";
    repeat (3) drive(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 10'h000, "reset");
    repeat (6) idle(2'b00);
    vid(8'h00, 10'h100);
    vid(8'h00, 10'h3FF);
    repeat (LAT - 1) idle(2'b00);
    check("cnt_first", int'(dut.cnt), -8);
    idle(2'b00);
    check("cnt_second", int'(dut.cnt), 2);
    repeat (4) idle(2'b00);
    for (int i = 0; i < 4; i++) repeat (2) idle(2'(i));
    repeat (4) idle(2'b00);
    vid(8'hFF, 10'h200);
    vid(8'h55, 10'h133);
    vid(8'h10, 10'h1F0);
    vid(8'h00, 10'h3FF);
    vid(8'h00, 10'h100);
    repeat (4) idle(2'b00);
    repeat (6) rvid(8'h00);
    drive(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 10'h000, "reset");
    vid(8'h00, 10'h100);
    vid(8'h00, 10'h3FF);
    repeat (5) idle(2'b00);
    repeat (3) rvid(8'($urandom));
    repeat (12) idle(2'b00);
    repeat (3) rvid(8'($urandom));
    idle(2'b00);
    repeat (3) rvid(8'($urandom));
    repeat (2) idle(2'b11);
    repeat (3) rvid(8'($urandom));
    repeat (4) idle(2'b00);
    for (int l = 0; l < 100; l++) begin
      repeat ($urandom_range(1, 4)) idle(2'($urandom_range(0, 3)));
      for (int i = 0; i < 100; i++) rvid(8'($urandom));
    end
    repeat (LAT + 2) idle(2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 The block SHALL have parameter CHANNEL, default 0, meaning the TMDS lane index 0..2; it selects the guard-band word.
REQ-002 The block SHALL have port clk, input, 1 bit: pixel clock; the single clock for all logic.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, 8 bits: pixel component, sampled when in_de=1.
REQ-005 The block SHALL have port in_de, input, 1 bit: video data enable.
REQ-006 The block SHALL have port in_c, input, 2 bits: control bits {C1,C0}, sampled when in_de=0.
REQ-007 The block SHALL have port out_tmds, output, 10 bits: encoded character; bit 0 is serialized first.

Function
REQ-008 Stage 1 SHALL compute q_m per DVI 1.0 minimisation: XNOR chain with q_m[8]=0 if N1(in_data)>4, or if N1=4 and in_data[0]=0; otherwise XOR chain with q_m[8]=1.
REQ-009 Stage 2 SHALL perform DC balancing with a signed 5-bit running disparity cnt, per DVI 1.0:
- cnt=0 or N1(q_m[7:0])=N0: out={~q_m[8],q_m[8],q_m[8]?q_m[7:0]:~q_m[7:0]}.
- (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out={1,q_m[8],~q_m[7:0]}, cnt+=2*q_m[8]+N0-N1.
- Otherwise: out={0,q_m[8],q_m[7:0]}, cnt+=N1-N0-2*~q_m[8].
- In the first case, cnt+=(q_m[8]?N1-N0:N0-N1).
REQ-010 When the delayed de=0, out_tmds SHALL be the control token for {C1,C0}: 00->0x354, 01->0x0AB, 10->0x154, 11->0x2AB; cnt SHALL be cleared to 0.
REQ-011 Without the guard-band feature, the latency from in_* to out_tmds SHALL be exactly 2 clk cycles, with data, de and c delayed identically.
REQ-012 The block SHALL accept a new character every cycle with no stall or handshake; any de pattern is legal, including a one-cycle de pulse or a one-cycle gap.
REQ-013 cnt arithmetic SHALL use a 5-bit signed range; by the algorithm, |cnt| never exceeds 8.
REQ-014 Consecutive video characters across a de gap SHALL NOT carry disparity, because the gap clears cnt.

Reset
REQ-015 While rst=1, all pipeline registers SHALL clear: de=0, c=00, data=0, cnt=0.
REQ-016 While rst=1, and until valid input propagates, out_tmds SHALL read 0x354.
REQ-017 rst asserted mid-line SHALL abort the line; the first output after release SHALL be a control token.

Configuration
REQ-018 When macro TMDS_GUARD_BAND_EN is defined, the block SHALL add 2 delay stages, giving latency 4.
REQ-019 With TMDS_GUARD_BAND_EN defined, the two output cycles immediately preceding a de 0->1 transition SHALL carry the video guard band instead of a control token: 0x2CC for CHANNEL 0 and 2, 0x133 for CHANNEL 1.
REQ-020 With TMDS_GUARD_BAND_EN defined, a de-low gap of 1 cycle SHALL emit one guard-band word, and a gap of 2 cycles SHALL emit two.
REQ-021 With TMDS_GUARD_BAND_EN defined, cnt SHALL remain 0 during guard-band cycles.
REQ-022 When TMDS_GUARD_BAND_EN is not defined, the block SHALL contain no lookahead logic, the latency SHALL be 2, and the guard-band word SHALL never appear.

Structure
REQ-023 A shared package tmds_pkg SHALL hold the four control-token constants, the two guard-band constants, and the popcount width constant.
REQ-024 A sub-module tmds_qm SHALL hold the combinational stage-1 minimisation plus its popcount; all other logic SHALL stay in tmds_encoder.

Verification
REQ-025 The bench SHALL apply rst then de=0, c=00 and require out_tmds=0x354 continuously, including during rst.
REQ-026 The bench SHALL apply de=1 with data 0x00, 0x00 after a control period and require out_tmds 0x100 then 0x3FF two cycles later, with cnt going -8 then +2.
REQ-027 The bench SHALL sweep c through 00/01/10/11 with de=0 and require out_tmds 0x354, 0x0AB, 0x154, 0x2AB at latency 2.
REQ-028 The bench SHALL drive 10,000 random video characters and require the decoded output to equal the input, and the running 1s-minus-0s count over the line to stay within ±10.
REQ-029 The bench SHALL assert rst for 1 cycle mid-line and require the next output to be 0x354 and the following video character to be encoded as if cnt=0.
REQ-030 The bench SHALL, with TMDS_GUARD_BAND_EN defined and CHANNEL=1, drive de 0->1 after a 12-cycle gap, and require 10 control tokens, 0x133, 0x133, then video at latency 4; with a 1-cycle gap it SHALL require exactly one 0x133.
